// File: rtl/round_fifo_if.sv
// Bundles the producer/consumer-facing signals of round_fifo.
//
// Optional macro: ROUND_FIFO_ERR_EN adds sticky Overflow/Underflow flags.
//
// Signals:
//   Push, Pop, DataIn        driven by the producer/consumer side (master)
//   DataOut, DataValid       registered read data and its one-cycle strobe
//   Full, Empty, Count       occupancy derived from the pointers and Round
//   W_Addr, R_Addr, Round    raw pointer state, exposed for observation
//   Overflow, Underflow      sticky error flags (only with ROUND_FIFO_ERR_EN)
//
// Modports:
//   master  the side that pushes and pops
//   slave   the FIFO itself
interface round_fifo_if #(
  parameter int DataWidth   = 8,
  parameter int BufferWidth = 4
);
  logic                   Push;
  logic                   Pop;
  logic [DataWidth-1:0]   DataIn;
  logic [DataWidth-1:0]   DataOut;
  logic                   DataValid;
  logic                   Full;
  logic                   Empty;
  logic [BufferWidth:0]   Count;
  logic [BufferWidth-1:0] W_Addr;
  logic [BufferWidth-1:0] R_Addr;
  logic                   Round;
`ifdef ROUND_FIFO_ERR_EN
  logic                   Overflow;
  logic                   Underflow;
`endif

  modport master (
    output Push, Pop, DataIn,
    input  DataOut, DataValid, Full, Empty, Count, W_Addr, R_Addr, Round
`ifdef ROUND_FIFO_ERR_EN
    , input Overflow, Underflow
`endif
  );

  modport slave (
    input  Push, Pop, DataIn,
    output DataOut, DataValid, Full, Empty, Count, W_Addr, R_Addr, Round
`ifdef ROUND_FIFO_ERR_EN
    , output Overflow, Underflow
`endif
  );
endinterface

// File: rtl/round_fifo.sv
// Circular FIFO feeding the MAC datapath. Full and Empty are told apart by
// the Round (wrap-parity) bit: when both pointers are equal, Round=1 means
// the write pointer is one lap ahead (full), Round=0 means empty.
//
// Optional macro: ROUND_FIFO_ERR_EN adds sticky Overflow (push on full
// without pop) and Underflow (pop on empty) flags, cleared only by rst.
//
// Ports:
//   clk  rising-edge clock
//   rst  asynchronous, active-high reset (memory contents are kept)
//   bus  round_fifo_if.slave: Push/Pop/DataIn in; DataOut/DataValid,
//        Full/Empty/Count, W_Addr/R_Addr/Round (and error flags) out
module round_fifo #(
  parameter int DataWidth   = 8,
  parameter int BufferWidth = 4
) (
  input  logic        clk,
  input  logic        rst,
  round_fifo_if.slave bus
);
  localparam int Depth = 2 ** BufferWidth;
  localparam logic [BufferWidth-1:0] LastAddr  = BufferWidth'(Depth - 1);
  localparam logic [BufferWidth:0]   DepthWide = (BufferWidth + 1)'(Depth);

  typedef enum logic {
    SAME  = 1'b0,
    AHEAD = 1'b1
  } round_state_t;

  logic [DataWidth-1:0]   mem [Depth];
  logic [BufferWidth-1:0] w_addr_reg;
  logic [BufferWidth-1:0] r_addr_reg;
  logic [DataWidth-1:0]   data_out_reg;
  logic                   data_valid_reg;
  round_state_t           state_reg;
  round_state_t           state_next;

  logic ptr_equal;
  logic full;
  logic empty;
  logic wr_en;
  logic rd_en;
  logic wrap_w;
  logic wrap_r;

  assign ptr_equal = (w_addr_reg == r_addr_reg);
  assign full      = (state_reg == AHEAD) && ptr_equal;
  assign empty     = (state_reg == SAME) && ptr_equal;

  // A pop on a full FIFO frees the slot the simultaneous push writes into.
  assign wr_en = bus.Push && (!full || bus.Pop);
  assign rd_en = bus.Pop && !empty;

  assign wrap_w = wr_en && (w_addr_reg == LastAddr);
  assign wrap_r = rd_en && (r_addr_reg == LastAddr);

  // Round flips on a single wrap; two wraps in one cycle cancel out.
  always_comb begin
    state_next = state_reg;
    if (wrap_w ^ wrap_r) begin
      state_next = (state_reg == SAME) ? AHEAD : SAME;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_reg      <= SAME;
      w_addr_reg     <= '0;
      r_addr_reg     <= '0;
      data_out_reg   <= '0;
      data_valid_reg <= 1'b0;
    end else begin
      state_reg      <= state_next;
      data_valid_reg <= rd_en;
      if (wr_en) begin
        w_addr_reg <= w_addr_reg + 1'b1;
      end
      if (rd_en) begin
        r_addr_reg   <= r_addr_reg + 1'b1;
        // Non-blocking read sees the old word even when the same-cycle
        // write targets this address (push+pop on full).
        data_out_reg <= mem[r_addr_reg];
      end
    end
  end

  // Storage has no reset so it can map onto block RAM.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem[w_addr_reg] <= bus.DataIn;
    end
  end

  assign bus.DataOut   = data_out_reg;
  assign bus.DataValid = data_valid_reg;
  assign bus.Full      = full;
  assign bus.Empty     = empty;
  assign bus.W_Addr    = w_addr_reg;
  assign bus.R_Addr    = r_addr_reg;
  assign bus.Round     = (state_reg == AHEAD);
  // Adding Depth when a lap ahead makes the modular difference exact,
  // including the full case where the pointers are equal.
  assign bus.Count     = {1'b0, w_addr_reg} - {1'b0, r_addr_reg}
                       + ((state_reg == AHEAD) ? DepthWide : '0);

`ifdef ROUND_FIFO_ERR_EN
  logic overflow_reg;
  logic underflow_reg;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      overflow_reg  <= 1'b0;
      underflow_reg <= 1'b0;
    end else begin
      if (bus.Push && full && !bus.Pop) begin
        overflow_reg <= 1'b1;
      end
      if (bus.Pop && empty) begin
        underflow_reg <= 1'b1;
      end
    end
  end

  assign bus.Overflow  = overflow_reg;
  assign bus.Underflow = underflow_reg;
`endif
endmodule

// File: tb/tb_round_fifo.sv
// Directed bench for round_fifo (DataWidth=8, BufferWidth=2, Depth=4).
// The stimulus process queues the word each accepted pop must return; a
// separate monitor pops that queue whenever DataValid is seen.
module tb_round_fifo;
  localparam int DW = 8;
  localparam int BW = 2;

  logic clk;
  logic rst;

  round_fifo_if #(.DataWidth(DW), .BufferWidth(BW)) bus ();

  round_fifo #(.DataWidth(DW), .BufferWidth(BW)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  logic [DW-1:0] exp_q [$];
  int tests;
  int fails;
  int mon_tests;
  int mon_fails;

  initial begin
    mon_tests = 0;
    mon_fails = 0;
  end

  // Monitor: every DataValid must match the oldest queued expectation.
  always @(negedge clk) begin
    if (bus.DataValid === 1'b1) begin
      mon_tests++;
      if (exp_q.size() == 0) begin
        mon_fails++;
        $display("[TB] FAIL unexpected_valid: DataOut=0x%02h with no pop outstanding", bus.DataOut);
      end else begin
        logic [DW-1:0] e;
        e = exp_q.pop_front();
        if (bus.DataOut !== e) begin
          mon_fails++;
          $display("[TB] FAIL pop_data: got 0x%02h expected 0x%02h", bus.DataOut, e);
        end else begin
          $display("[TB] pop data 0x%02h ok", bus.DataOut);
        end
      end
    end
  end

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("[TB] FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // One clock: drive inputs, take the edge, release inputs 1 time unit later.
  task automatic cycle(input logic p, input logic q, input logic [DW-1:0] d);
    bus.Push   = p;
    bus.Pop    = q;
    bus.DataIn = d;
    @(posedge clk);
    #1;
    bus.Push   = 1'b0;
    bus.Pop    = 1'b0;
    bus.DataIn = '0;
    $display("[TB] cycle push=%0b pop=%0b din=0x%02h -> count=%0d w=%0d r=%0d round=%0b",
             p, q, d, bus.Count, bus.W_Addr, bus.R_Addr, bus.Round);
  endtask

  task automatic push(input logic [DW-1:0] d);
    cycle(1'b1, 1'b0, d);
  endtask

  task automatic pop_exp(input logic [DW-1:0] e);
    exp_q.push_back(e);
    cycle(1'b0, 1'b1, '0);
  endtask

  task automatic do_reset();
    rst = 1'b1;
    #3;
    rst = 1'b0;
  endtask

  initial begin
    #100000;
    $display("[TB] FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    tests = 0;
    fails = 0;
    rst = 1'b1;
    bus.Push = 1'b0;
    bus.Pop = 1'b0;
    bus.DataIn = '0;
    repeat (2) @(posedge clk);
    #1 rst = 1'b0;

    // 1. reset then idle
    cycle(1'b0, 1'b0, '0);
    check("rst_empty", 32'(bus.Empty), 1);
    check("rst_full", 32'(bus.Full), 0);
    check("rst_count", 32'(bus.Count), 0);
    check("rst_waddr", 32'(bus.W_Addr), 0);
    check("rst_raddr", 32'(bus.R_Addr), 0);
    check("rst_round", 32'(bus.Round), 0);
    check("rst_valid", 32'(bus.DataValid), 0);
    check("rst_dout", 32'(bus.DataOut), 0);

    // 2. fill, then overflow attempt
    push(8'h11);
    check("fill1_count", 32'(bus.Count), 1);
    check("fill1_empty", 32'(bus.Empty), 0);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    check("full_full", 32'(bus.Full), 1);
    check("full_count", 32'(bus.Count), 4);
    check("full_waddr", 32'(bus.W_Addr), 0);
    check("full_raddr", 32'(bus.R_Addr), 0);
    check("full_round", 32'(bus.Round), 1);
    push(8'h55);
    check("ovf_count", 32'(bus.Count), 4);
    check("ovf_waddr", 32'(bus.W_Addr), 0);
`ifdef ROUND_FIFO_ERR_EN
    check("ovf_flag", 32'(bus.Overflow), 1);
    check("ovf_no_udf", 32'(bus.Underflow), 0);
`endif

    // 3. drain, then underflow attempt
    pop_exp(8'h11);
    pop_exp(8'h22);
    pop_exp(8'h33);
    pop_exp(8'h44);
    check("drain_valid", 32'(bus.DataValid), 1);
    check("drain_empty", 32'(bus.Empty), 1);
    check("drain_round", 32'(bus.Round), 0);
    check("drain_count", 32'(bus.Count), 0);
    cycle(1'b0, 1'b1, '0);
    check("udf_valid", 32'(bus.DataValid), 0);
    check("udf_dout_hold", 32'(bus.DataOut), 32'h44);
    check("udf_raddr", 32'(bus.R_Addr), 0);
`ifdef ROUND_FIFO_ERR_EN
    check("udf_flag", 32'(bus.Underflow), 1);
`endif

    // 4. push+pop on full: read-before-write
    push(8'h11);
    push(8'h22);
    push(8'h33);
    push(8'h44);
    exp_q.push_back(8'h11);
    cycle(1'b1, 1'b1, 8'hAA);
    check("pp_full_count", 32'(bus.Count), 4);
    check("pp_full_full", 32'(bus.Full), 1);
    check("pp_full_waddr", 32'(bus.W_Addr), 1);
    check("pp_full_raddr", 32'(bus.R_Addr), 1);
    pop_exp(8'h22);
    pop_exp(8'h33);
    pop_exp(8'h44);
    pop_exp(8'hAA);
    check("pp_drain_empty", 32'(bus.Empty), 1);
    cycle(1'b0, 1'b0, '0);

    // 5. empty with pointers at 3, push+pop together
    do_reset();
    push(8'h01);
    push(8'h02);
    push(8'h03);
    pop_exp(8'h01);
    pop_exp(8'h02);
    pop_exp(8'h03);
    check("prime_waddr", 32'(bus.W_Addr), 3);
    check("prime_empty", 32'(bus.Empty), 1);
    cycle(1'b1, 1'b1, 8'h77);
    check("pe_count", 32'(bus.Count), 1);
    check("pe_waddr", 32'(bus.W_Addr), 0);
    check("pe_raddr", 32'(bus.R_Addr), 3);
    check("pe_round", 32'(bus.Round), 1);
    check("pe_valid", 32'(bus.DataValid), 0);
    check("pe_full", 32'(bus.Full), 0);

    // 6. asynchronous reset with Count=2
    push(8'h88);
    check("mid_count", 32'(bus.Count), 2);
    #2 rst = 1'b1;
    #1;
    check("arst_count", 32'(bus.Count), 0);
    check("arst_empty", 32'(bus.Empty), 1);
    check("arst_waddr", 32'(bus.W_Addr), 0);
    check("arst_raddr", 32'(bus.R_Addr), 0);
    check("arst_round", 32'(bus.Round), 0);
    check("arst_dout", 32'(bus.DataOut), 0);
`ifdef ROUND_FIFO_ERR_EN
    check("arst_udf", 32'(bus.Underflow), 0);
`endif
    #1 rst = 1'b0;
    push(8'h99);
    check("post_waddr", 32'(bus.W_Addr), 1);
    pop_exp(8'h99);
    cycle(1'b0, 1'b0, '0);
    cycle(1'b0, 1'b0, '0);

    check("all_pops_seen", 32'(exp_q.size()), 0);
    tests += mon_tests;
    fails += mon_fails;
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
